q_meter: RTL and testbench

Q_METER -- requirements
Module: q_meter

---
 rtl/q_ctrl_pkg.sv | 19 +
 rtl/q_accum.sv | 40 ++++
 rtl/q_meter.sv | 132 +++++++++++++
 tb/tb_q_meter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_ctrl_pkg.sv
// Shared definitions for the Q measurement path and the bisection controller:
// FSM state encoding, default bus width and accumulator width helper.
package q_ctrl_pkg;

    localparam int Q_WIDTH_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETTLE    = 2'd1,
        INTEGRATE = 2'd2,
        DONE      = 2'd3
    } q_state_t;

    // Summing 2^log2_n samples of width bits never needs more than this.
    function automatic int q_acc_width(input int width, input int log2_n);
        return width + log2_n;
    endfunction

endpackage

// File: rtl/q_accum.sv
// Sample accumulator and sample counter for one Q measurement; clear wins over add.
// count_done flags that the sample being added now is the last one of the set.
module q_accum
    import q_ctrl_pkg::*;
#(
    parameter int WIDTH  = Q_WIDTH_DEFAULT,
    parameter int LOG2_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] result,
    output logic             count_done
);

    localparam int AW = q_acc_width(WIDTH, LOG2_N);
    localparam logic [LOG2_N:0] LAST = (LOG2_N + 1)'((1 << LOG2_N) - 1);

    logic [AW-1:0]   acc;
    logic [AW-1:0]   sum;
    logic [LOG2_N:0] count;

    // result already includes the sample presented this cycle
    assign sum        = acc + AW'(sample);
    assign result     = sum[AW-1:LOG2_N];
    assign count_done = add && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc   <= '0;
            count <= '0;
        end else if (add) begin
            acc   <= sum;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/q_meter.sv
// Q measurement sequencer: settles after each reference change, averages 2^LOG2_N samples.
// Define Q_METER_SETTLE_EN to include the SETTLE state and its down-counter.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | disabled; waits for en, then captures i_ref
// SETTLE    | waits SETTLE_CYC cycles for the reference to settle
// INTEGRATE | accumulates valid samples until 2^LOG2_N are taken
// DONE      | measured_q valid for the captured reference; ready held high
module q_meter
    import q_ctrl_pkg::*;
#(
    parameter int WIDTH      = Q_WIDTH_DEFAULT,
    parameter int LOG2_N     = 3,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] i_ref,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] measured_q,
    output logic             ready,
    output logic             busy
);

    q_state_t         state;
    q_state_t         state_nxt;
    q_state_t         start_state;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] acc_result;
    logic             acc_clr;
    logic             acc_add;
    logic             count_done;
    logic             load_ref;
    logic             load_q;
    logic             ready_nxt;
    logic             restart;

`ifdef Q_METER_SETTLE_EN
    localparam int SC = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam int CW = $clog2(SC + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SC - 1);

    logic [CW-1:0] settle_cnt;
    logic          settle_tc;

    assign settle_tc   = (settle_cnt == '0);
    assign start_state = SETTLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (load_ref) begin
            settle_cnt <= SETTLE_LOAD;
        end else if (state == SETTLE && !settle_tc) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end
`else
    assign start_state = INTEGRATE;
`endif

    q_accum #(
        .WIDTH  (WIDTH),
        .LOG2_N (LOG2_N)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (acc_clr),
        .add        (acc_add),
        .sample     (sample),
        .result     (acc_result),
        .count_done (count_done)
    );

    assign restart = (state != IDLE) && (i_ref != ref_q);

    // Priority: disable, then start/restart (drops any same-cycle sample), then normal flow.
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;
        load_ref  = 1'b0;
        load_q    = 1'b0;
        ready_nxt = ready;
        if (!en) begin
            state_nxt = IDLE;
            ready_nxt = 1'b0;
        end else if (state == IDLE || restart) begin
            state_nxt = start_state;
            acc_clr   = 1'b1;
            load_ref  = 1'b1;
            ready_nxt = 1'b0;
        end else begin
            case (state)
`ifdef Q_METER_SETTLE_EN
                SETTLE: begin
                    if (settle_tc) state_nxt = INTEGRATE;
                end
`endif
                INTEGRATE: begin
                    acc_add = sample_valid;
                    if (count_done) begin
                        load_q    = 1'b1;
                        ready_nxt = 1'b1;
                        state_nxt = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ref_q      <= '0;
            measured_q <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= ready_nxt;
            busy  <= (state_nxt == SETTLE) || (state_nxt == INTEGRATE);
            if (load_ref) ref_q <= i_ref;
            if (load_q) measured_q <= acc_result;
        end
    end

endmodule

// File: tb/tb_q_meter.sv
// Self-checking bench for q_meter: directed scenarios plus randomized samples,
// with expected averages computed from the sample lists fed in.
module tb_q_meter;

`ifdef Q_METER_SETTLE_EN
    localparam int SETTLE = 4;
`else
    localparam int SETTLE = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [9:0] i_ref;
    logic       sample_valid;
    logic [9:0] sample;
    logic [9:0] measured_q;
    logic       ready;
    logic       busy;

    int         tests = 0;
    int         fails = 0;
    int         busy_cnt = 0;
    int         exp_q = 0;
    logic [9:0] vals[$];

    q_meter #(
        .WIDTH      (10),
        .LOG2_N     (3),
        .SETTLE_CYC (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .i_ref        (i_ref),
        .sample_valid (sample_valid),
        .sample       (sample),
        .measured_q   (measured_q),
        .ready        (ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy === 1'b1) busy_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // From IDLE: enable with a new reference.
    task automatic start(input logic [9:0] r);
        en = 1'b1;
        i_ref = r;
        sample_valid = 1'b0;
        tick();
        chk("start_busy", busy, 1);
        chk("start_ready", ready, 0);
    endtask

    // Settle window: junk samples presented here must be ignored.
    task automatic settle();
        repeat (SETTLE) begin
            sample_valid = 1'b1;
            sample = 10'($urandom_range(0, 1023));
            tick();
            chk("settle_busy", busy, 1);
            chk("settle_ready", ready, 0);
        end
        sample_valid = 1'b0;
    endtask

    // Feed vals; the 8th accepted sample must publish floor(sum/8).
    task automatic feed(input bit gaps);
        int sum = 0;
        int k = 0;
        foreach (vals[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    sample_valid = 1'b0;
                    sample = 10'($urandom_range(0, 1023));
                    tick();
                    chk("gap_ready", ready, 0);
                    chk("gap_busy", busy, 1);
                end
            end
            sample_valid = 1'b1;
            sample = vals[i];
            tick();
            sample_valid = 1'b0;
            sum += int'(vals[i]);
            k++;
            if (k == 8) begin
                exp_q = sum / 8;
                chk("done_ready", ready, 1);
                chk("done_q", measured_q, exp_q);
                chk("done_busy", busy, 0);
            end else begin
                chk("acc_ready", ready, 0);
                chk("acc_busy", busy, 1);
            end
        end
    endtask

    task automatic disable_once();
        en = 1'b0;
        sample_valid = 1'b0;
        tick();
        chk("dis_ready", ready, 0);
        chk("dis_busy", busy, 0);
        chk("dis_hold_q", measured_q, exp_q);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        i_ref = '0;
        sample_valid = 1'b0;
        sample = '0;
        tick();
        tick();
        chk("rst_q", measured_q, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // basic measurement
        busy_cnt = 0;
        start(10'd512);
        settle();
        vals = {};
        repeat (8) vals.push_back(10'd100);
        feed(1'b0);
        chk("basic_q", measured_q, 100);
        chk("basic_busy_cycles", busy_cnt, SETTLE + 8);
        repeat (3) begin
            sample_valid = 1'($urandom_range(0, 1));
            sample = 10'($urandom_range(0, 1023));
            tick();
            chk("hold_ready", ready, 1);
            chk("hold_q", measured_q, 100);
        end

        // disable mid-integration keeps the old result
        disable_once();
        start(10'd300);
        settle();
        vals = {};
        repeat (3) vals.push_back(10'($urandom_range(0, 1023)));
        feed(1'b1);
        en = 1'b0;
        sample_valid = 1'b1;
        sample = 10'd1000;
        tick();
        chk("en0_int_ready", ready, 0);
        chk("en0_int_busy", busy, 0);
        chk("en0_int_q", measured_q, 100);
        sample_valid = 1'b0;

        // truncation
        start(10'd512);
        settle();
        vals = {};
        for (int i = 0; i < 8; i++) vals.push_back(10'(i));
        feed(1'b0);
        chk("round_q", measured_q, 3);

        // restart after 5 samples; the same-cycle sample is dropped
        disable_once();
        start(10'd512);
        settle();
        vals = {};
        repeat (5) vals.push_back(10'd900);
        feed(1'b0);
        i_ref = 10'd256;
        sample_valid = 1'b1;
        sample = 10'd1000;
        tick();
        chk("restart_ready", ready, 0);
        chk("restart_busy", busy, 1);
        chk("restart_q", measured_q, 3);
        settle();
        vals = {};
        repeat (8) vals.push_back(10'd200);
        feed(1'b0);
        chk("restart_final_q", measured_q, 200);

        // final sample collides with a reference change: restart wins
        disable_once();
        start(10'd100);
        settle();
        vals = {};
        repeat (7) vals.push_back(10'($urandom_range(0, 1023)));
        feed(1'b1);
        i_ref = 10'd101;
        sample_valid = 1'b1;
        sample = 10'd1023;
        tick();
        chk("collide_ready", ready, 0);
        chk("collide_q", measured_q, 200);
        chk("collide_busy", busy, 1);
        settle();
        vals = {};
        repeat (8) vals.push_back(10'($urandom_range(0, 1023)));
        feed(1'b1);

        // en=0 together with a reference change: disable wins
        disable_once();
        start(10'd700);
        settle();
        vals = {};
        repeat (2) vals.push_back(10'($urandom_range(0, 1023)));
        feed(1'b0);
        en = 1'b0;
        i_ref = 10'd701;
        tick();
        chk("en_prio_busy", busy, 0);
        chk("en_prio_ready", ready, 0);

        // full scale
        start(10'd701);
        settle();
        vals = {};
        repeat (8) vals.push_back(10'd1023);
        feed(1'b0);
        chk("fullscale_q", measured_q, 1023);

        // randomized measurements
        for (int n = 0; n < 4; n++) begin
            disable_once();
            start(10'($urandom_range(0, 1023)));
            settle();
            vals = {};
            repeat (8) vals.push_back(10'($urandom_range(0, 1023)));
            feed(1'b1);
        end

        // reset in DONE
        rst_n = 1'b0;
        en = 1'b0;
        tick();
        chk("rst_done_q", measured_q, 0);
        chk("rst_done_ready", ready, 0);
        chk("rst_done_busy", busy, 0);
        exp_q = 0;
        rst_n = 1'b1;

        // reset mid-integration publishes nothing, then a fresh run works
        start(10'd50);
        settle();
        vals = {};
        repeat (7) vals.push_back(10'($urandom_range(0, 1023)));
        feed(1'b1);
        rst_n = 1'b0;
        en = 1'b0;
        sample_valid = 1'b1;
        sample = 10'd1023;
        tick();
        chk("rst_mid_q", measured_q, 0);
        chk("rst_mid_ready", ready, 0);
        chk("rst_mid_busy", busy, 0);
        rst_n = 1'b1;
        sample_valid = 1'b0;
        start(10'd50);
        settle();
        vals = {};
        repeat (8) vals.push_back(10'($urandom_range(0, 1023)));
        feed(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
